// File: rtl/qam_iq_slicer.sv
// Two-channel integrate-and-dump 16QAM/QPSK slicer: SPS valid samples per symbol are
// summed per channel, then sliced on sign and magnitude against a threshold.
module qam_iq_lane #(
    parameter int DATA_W = 20,
    parameter int ACC_W  = 23
) (
    input  logic                     carrier_clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] data,
    input  logic                     acc_en,
    input  logic                     restart,
    input  logic                     dump_en,
    input  logic                     dec_en,
    input  logic                     mode_cap,
    input  logic [ACC_W-2:0]         thr_cap,
    output logic [1:0]               dec
);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc, dump, base, sum;
    logic [ACC_W-2:0]        mag;
    logic                    sign_bit;

    // align restarts the sum from zero so a same-cycle sample becomes sample 0
    assign base = restart ? '0 : acc;
    assign sum  = base + ACC_W'(data);

    always_ff @(posedge carrier_clk) begin
        if (reset) begin
            acc  <= '0;
            dump <= '0;
        end else begin
            if (dump_en)
                acc <= '0;
            else if (acc_en)
                acc <= sum;
            else if (restart)
                acc <= '0;
            if (dump_en)
                dump <= sum;
        end
    end

    always_comb begin
        sign_bit = dump[ACC_W-1] || (dump == '0);
        if (dump == ACC_MIN)
            mag = '1;
        else if (dump[ACC_W-1])
            mag = (ACC_W-1)'(-dump);
        else
            mag = dump[ACC_W-2:0];
    end

    always_ff @(posedge carrier_clk) begin
        if (reset)
            dec <= '0;
        else if (dec_en)
            dec <= {sign_bit, mode_cap && (mag > thr_cap)};
    end
endmodule

module qam_iq_slicer #(
    parameter int DATA_W = 20,
    parameter int SPS    = 8,
    parameter int ACC_W  = DATA_W + $clog2(SPS),
    parameter int CNT_W  = 16
) (
    input  logic                     carrier_clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] q_data,
    input  logic                     in_valid,
    input  logic                     align,
    input  logic                     mode,
    input  logic [ACC_W-2:0]         thr,
    output logic [3:0]               sym,
    output logic                     sym_valid,
    output logic [CNT_W-1:0]         sym_cnt
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 2;
    localparam int CW        = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SPS - 1);

    logic [CW-1:0]                       cnt;
    logic                                last, dump_en;
    logic [STAGES:0]                     vld_pipe;
    logic                                mode_cap;
    logic [ACC_W-2:0]                    thr_cap;
    logic [NUM_LANES-1:0][DATA_W-1:0]    lane_data;
    logic [NUM_LANES-1:0][1:0]           lane_dec;

    // align wins over a pending dump; only SPS=1 dumps the aligning sample itself
    assign last      = align ? (SPS == 1) : (cnt == LAST);
    assign dump_en   = in_valid && last;
    assign lane_data = {q_data, i_data};

    always_ff @(posedge carrier_clk) begin
        if (reset) begin
            cnt      <= '0;
            vld_pipe <= '0;
            mode_cap <= 1'b0;
            thr_cap  <= '0;
        end else begin
            if (dump_en)
                cnt <= '0;
            else if (in_valid)
                cnt <= (align ? '0 : cnt) + 1'b1;
            else if (align)
                cnt <= '0;
            if (dump_en) begin
                mode_cap <= mode;
                thr_cap  <= thr;
            end
            vld_pipe <= {vld_pipe[STAGES-1:0], dump_en};
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        qam_iq_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
            .carrier_clk (carrier_clk),
            .reset       (reset),
            .data        (lane_data[g]),
            .acc_en      (in_valid),
            .restart     (align),
            .dump_en     (dump_en),
            .dec_en      (vld_pipe[0]),
            .mode_cap    (mode_cap),
            .thr_cap     (thr_cap),
            .dec         (lane_dec[g])
        );
    end

    always_ff @(posedge carrier_clk) begin
        if (reset) begin
            sym     <= '0;
            sym_cnt <= '0;
        end else if (vld_pipe[STAGES-1]) begin
            sym     <= {lane_dec[0], lane_dec[1]};
            sym_cnt <= sym_cnt + 1'b1;
        end
    end

    assign sym_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_qam_iq_slicer.sv
// Scoreboard bench for qam_iq_slicer: one SPS=4 instance and one SPS=1 instance,
// expected symbols computed from whole-symbol sums and pushed with their due cycle.
module tb_qam_iq_slicer;
    localparam int DW = 20;
    localparam int A4 = 22;
    localparam int A1 = 20;

    logic carrier_clk = 1'b0;
    logic reset = 1'b1;
    always #5 carrier_clk = ~carrier_clk;

    logic signed [DW-1:0] i4 = '0, q4 = '0, i1 = '0, q1 = '0;
    logic v4 = 1'b0, al4 = 1'b0, m4 = 1'b0, v1 = 1'b0, al1 = 1'b0, m1 = 1'b0;
    logic [A4-2:0] thr4 = '0;
    logic [A1-2:0] thr1 = '0;
    logic [3:0]  sym4, sym1;
    logic        sv4, sv1;
    logic [15:0] cnt4, cnt1;

    qam_iq_slicer #(.DATA_W(DW), .SPS(4), .CNT_W(16)) dut4 (
        .carrier_clk(carrier_clk), .reset(reset), .i_data(i4), .q_data(q4),
        .in_valid(v4), .align(al4), .mode(m4), .thr(thr4),
        .sym(sym4), .sym_valid(sv4), .sym_cnt(cnt4));

    qam_iq_slicer #(.DATA_W(DW), .SPS(1), .CNT_W(16)) dut1 (
        .carrier_clk(carrier_clk), .reset(reset), .i_data(i1), .q_data(q1),
        .in_valid(v1), .align(al1), .mode(m1), .thr(thr1),
        .sym(sym1), .sym_valid(sv1), .sym_cnt(cnt1));

    typedef struct {
        logic [3:0] sym;
        int         cnt;
        longint     due;
    } exp_t;

    exp_t   q4e[$], q1e[$];
    int     ci[$], cq[$];
    longint cyc = 0;
    int     nchk = 0, nfail = 0;
    int     exp_cnt4 = 0, exp_cnt1 = 0;
    logic [3:0] last4 = '0;

    always @(posedge carrier_clk) cyc <= cyc + 1;

    function automatic logic [1:0] decide(longint s, bit md, longint th, int aw);
        longint mag, mx;
        mag = (s < 0) ? -s : s;
        mx  = (longint'(1) << (aw - 1)) - 1;
        if (mag > mx) mag = mx;
        return {s <= 0, md && (mag > th)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called just after a rising edge; the sample is accepted on the next edge.
    task automatic send4(int iv, int qv, bit al);
        longint si, sq;
        i4 = iv[DW-1:0]; q4 = qv[DW-1:0]; v4 = 1'b1; al4 = al;
        if (al) begin ci.delete(); cq.delete(); end
        ci.push_back(iv); cq.push_back(qv);
        if (ci.size() == 4) begin
            si = 0; sq = 0;
            foreach (ci[k]) begin si += ci[k]; sq += cq[k]; end
            exp_cnt4 = (exp_cnt4 + 1) % 65536;
            q4e.push_back('{{decide(si, m4, longint'(thr4), A4), decide(sq, m4, longint'(thr4), A4)},
                            exp_cnt4, cyc + 3});
            ci.delete(); cq.delete();
        end
        @(posedge carrier_clk); #1;
        v4 = 1'b0; al4 = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge carrier_clk); #1; end
    endtask

    task automatic align_only4();
        al4 = 1'b1; ci.delete(); cq.delete();
        @(posedge carrier_clk); #1;
        al4 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        while (q4e.size() > 0 && q4e[$].due > cyc) void'(q4e.pop_back());
        while (q1e.size() > 0 && q1e[$].due > cyc) void'(q1e.pop_back());
        ci.delete(); cq.delete();
        exp_cnt4 = 0; exp_cnt1 = 0;
        @(posedge carrier_clk); #1;
        last4 = '0;
        chk("rst_sym", 64'(sym4), 0);
        chk("rst_valid", 64'(sv4), 0);
        chk("rst_cnt", 64'(cnt4), 0);
        reset = 1'b0;
    endtask

    always @(negedge carrier_clk) begin
        exp_t e;
        if (sv4 === 1'b1) begin
            if (q4e.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL spurious4: got sym %0d want no symbol (cycle %0d)", sym4, cyc);
            end else begin
                e = q4e.pop_front();
                chk("sym4", 64'(sym4), 64'(e.sym));
                chk("cnt4", 64'(cnt4), 64'(e.cnt));
                chk("lat4", 64'(cyc), 64'(e.due));
                last4 = e.sym;
            end
        end else begin
            if (q4e.size() > 0 && q4e[0].due <= cyc) begin
                e = q4e.pop_front();
                nchk++; nfail++;
                $display("FAIL missing4: got no symbol want sym %0d (cycle %0d)", e.sym, cyc);
            end
            chk("hold4", 64'(sym4), 64'(last4));
        end
    end

    always @(negedge carrier_clk) begin
        exp_t e;
        if (sv1 === 1'b1) begin
            if (q1e.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL spurious1: got sym %0d want no symbol (cycle %0d)", sym1, cyc);
            end else begin
                e = q1e.pop_front();
                chk("sym1", 64'(sym1), 64'(e.sym));
                chk("cnt1", 64'(cnt1), 64'(e.cnt));
                chk("lat1", 64'(cyc), 64'(e.due));
            end
        end else if (q1e.size() > 0 && q1e[0].due <= cyc) begin
            e = q1e.pop_front();
            nchk++; nfail++;
            $display("FAIL missing1: got no symbol want sym %0d (cycle %0d)", e.sym, cyc);
        end
    end

    initial begin
        int ti, tq, t1;
        @(posedge carrier_clk); #1;
        do_reset();

        m4 = 1'b1; thr4 = 21'd20000;
        repeat (4) send4(6000, -1000, 1'b0);
        idle(4);
        m4 = 1'b0;
        repeat (4) send4(6000, -1000, 1'b0);
        idle(4);
        m4 = 1'b1;
        repeat (4) send4(5000, -1000, 1'b0);
        idle(4);
        repeat (4) send4(0, 0, 1'b0);
        idle(4);
        repeat (4) begin send4(0, 0, 1'b0); idle(3); end
        idle(2);

        repeat (2) send4(9000, 500, 1'b0);
        send4(9000, 500, 1'b1);
        repeat (3) send4(9000, 500, 1'b0);
        idle(4);
        send4(-3000, 4000, 1'b0);
        align_only4();
        repeat (4) send4(-3000, 7000, 1'b0);
        idle(4);

        repeat (3) send4(7000, 7000, 1'b0);
        do_reset();
        repeat (4) send4(6000, -9000, 1'b0);
        idle(4);
        repeat (4) send4(-8000, 3000, 1'b0);
        do_reset();
        repeat (4) send4(-6000, 6000, 1'b0);
        idle(4);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) m4 = 1'($urandom);
            thr4 = (A4-1)'($urandom_range(0, 40000));
            ti = int'($urandom_range(0, 30000)) - 15000;
            tq = int'($urandom_range(0, 30000)) - 15000;
            if ($urandom_range(0, 9) == 0) ti = $urandom_range(0, 1) ? -524288 : 524287;
            if ($urandom_range(0, 9) == 0) tq = $urandom_range(0, 1) ? -524288 : 524287;
            send4(ti, tq, $urandom_range(0, 15) == 0);
        end
        idle(6);

        m1 = 1'b1; thr1 = '1;
        t1 = -524288;
        for (int n = 0; n < 65540; n++) begin
            tq = int'($urandom_range(0, 1048575)) - 524288;
            i1 = t1[DW-1:0]; q1 = tq[DW-1:0]; v1 = 1'b1;
            exp_cnt1 = (exp_cnt1 + 1) % 65536;
            q1e.push_back('{{decide(longint'(t1), m1, longint'(thr1), A1),
                             decide(longint'(tq), m1, longint'(thr1), A1)}, exp_cnt1, cyc + 3});
            @(posedge carrier_clk); #1;
        end
        v1 = 1'b0;
        idle(6);

        chk("drain4", 64'(q4e.size()), 0);
        chk("drain1", 64'(q1e.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/qam_iq_slicer.md
Name: qam_iq_slicer

Overview:
- Parametrised two-channel (I/Q) 16QAM/QPSK decision block.
- Integrate-and-dump over SPS valid samples per symbol, then per-channel sign and magnitude-threshold decision.
- Emits one 4-bit symbol with a valid pulse.
- Sits after the I and Q matched FIRs and feeds the symbol demapper/serializer; a single carrier-rate clock with a valid qualifier replaces the separate symbol clock.

Parameters:
- DATA_W, 20: signed width of i_data/q_data.
- SPS, 8: valid samples integrated per symbol; must be at least 1.
- ACC_W, DATA_W+$clog2(SPS): signed accumulator width; the threshold is ACC_W-1 bits unsigned.
- CNT_W, 16: width of the symbol counter.

Ports:
- carrier_clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_data  in  DATA_W  signed I-channel FIR output.
- q_data  in  DATA_W  signed Q-channel FIR output.
- in_valid  in  1  i_data/q_data qualifier.
- align  in  1  symbol-boundary resync pulse.
- mode  in  1  0 = QPSK (sign only), 1 = 16QAM.
- thr  in  ACC_W-1  unsigned magnitude threshold applied to the integrated sum.
- sym  out  4  {I_sign, I_mag, Q_sign, Q_mag}.
- sym_valid  out  1  one-cycle pulse when sym updates.
- sym_cnt  out  CNT_W  count of emitted symbols, wraps.

Behaviour:
- Reset, sampled at the carrier_clk edge: sym=0, sym_valid=0, sym_cnt=0, accumulators=0, sample counter=0, pipeline valids=0. Reset asserted mid-symbol discards the partial sum; no output is produced for it.
- Accumulate: on in_valid=1, acc_i += i_data and acc_q += q_data, both sign-extended to ACC_W. The sample counter advances 0..SPS-1. in_valid=0 holds all state (gaps allowed).
- Dump: when a valid sample arrives with counter==SPS-1:
  - Latch the dump registers: dump_i = acc_i + i_data, dump_q likewise.
  - Capture thr and mode into the dump stage.
  - Clear the accumulators and counter in the same cycle; the next valid sample starts a new symbol.
  - With SPS=1, every valid sample dumps.
- Decision stage, one cycle after the dump:
  - sign = 1 when dump <= 0, 0 when dump > 0. Zero maps to 1.
  - mag = |dump|. The most negative ACC_W value saturates to 2^(ACC_W-1)-1.
  - mag bit = 1 when mag > thr, strictly greater (equality gives 0), and only when captured mode=1. In mode=0 both mag bits are 0.
- Output timing:
  - sym and sym_valid are registered; sym_valid rises exactly 2 cycles after the carrier_clk edge that accepted the last sample of a symbol.
  - sym holds its value between pulses.
  - sym_cnt increments, modulo 2^CNT_W, in the same cycle sym_valid=1.
- Back-to-back dumps (SPS=1, continuous valid): sym_valid stays high every cycle; the pipeline fully overlaps with no stall.
- align=1:
  - Clears the accumulators and counter.
  - If in_valid=1 in the same cycle, that sample becomes sample 0 of the new symbol (acc = sample, counter = 1; if SPS=1 it dumps immediately).
  - The partial symbol is discarded.
  - Symbols already in the dump or decision stage still emit.
- align and dump in the same cycle: align wins; no dump is issued for the discarded partial sum.
- mode and thr changes take effect from the next dump; a symbol in flight uses its captured values.
- There is no backpressure; the downstream block must accept sym on every sym_valid.

Test Plan:
- SPS=4, mode=1, thr=20000; 4 valid samples i=6000, q=-1000 -> sym=4'b0110 (I pos/outer, Q neg/inner), sym_valid for 1 cycle, 2 cycles after the 4th sample; sym_cnt=1.
- Same stimulus with mode=0 -> sym=4'b0010. Then i=5000 x4 (sum 20000 = thr), mode=1 -> I_mag=0 (equality is not greater).
- i=q=0 for 4 samples -> sym=4'b1010 (zero maps to sign=1). Insert in_valid gaps of 3 cycles between samples -> same sym; timing measured from the last accepted sample.
- SPS=1, DATA_W=20, thr=524287, i=-524288 continuous valid -> magnitude saturates to 524287, I bits=10; sym_valid high every cycle; sym_cnt wraps from 65535 to 0.
- SPS=4: after 2 samples assert align alongside a valid sample of +9000, then 3 more samples of +9000 -> exactly one symbol emitted, I sum=36000; the partial sum is not emitted.
- Assert reset after 3 of 4 samples and while a decision is in flight -> sym=0, sym_valid=0, sym_cnt=0 on the next edge; the following 4 samples produce a correct symbol with sym_cnt=1.
